fold_ctrl: RTL

FOLD_CTRL -- requirements
Module: fold_ctrl

---
 rtl/fold_pkg.sv | 26 ++
 rtl/fold_phase_gen.sv | 64 ++++++
 rtl/fold_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fold_pkg.sv
// Shared types and defaults for the folding controller.
//   fold_state_e : controller FSM states
//   fold_cfg_t   : shadow copy of the run configuration, latched on start
package fold_pkg;

  localparam int unsigned NBINS_DEF  = 256;
  localparam int unsigned BIN_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StEpoch,
    StFold,
    StDrain,
    StDone
  } fold_state_e;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] epoch;
    logic [15:0] bin_len;
    logic [15:0] nfold;
  } fold_cfg_t;

endpackage

// File: rtl/fold_phase_gen.sv
// Phase / sub-bin / bin counter chain for one fold period.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_run        counters advance while high, held at zero while low
//   i_period     fold period in cycles (non-zero)
//   i_bin_len    cycles per bin (non-zero)
//   o_bin        current bin, saturating at NBINS-1
//   o_wrap       high in the last cycle of a period while running
module fold_phase_gen
  import fold_pkg::*;
#(
  parameter int unsigned NBINS = NBINS_DEF,
  parameter int unsigned BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [31:0]      i_period,
  input  logic [15:0]      i_bin_len,
  output logic [BIN_W-1:0] o_bin,
  output logic             o_wrap
);

  logic [31:0]      r_phase;
  logic [31:0]      r_sub;
  logic [BIN_W-1:0] r_bin;

  logic [31:0]      w_period_last;
  logic [31:0]      w_sub_last;
  logic             w_sub_wrap;
  logic [BIN_W-1:0] w_bin_max;

  assign w_period_last = i_period - 32'd1;
  assign w_sub_last    = {16'd0, i_bin_len} - 32'd1;
  assign w_sub_wrap    = (r_sub == w_sub_last);
  assign w_bin_max     = BIN_W'(NBINS - 1);

  assign o_wrap = i_run && (r_phase == w_period_last);
  assign o_bin  = r_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_sub   <= '0;
      r_bin   <= '0;
    end else if (!i_run || o_wrap) begin
      r_phase <= '0;
      r_sub   <= '0;
      r_bin   <= '0;
    end else begin
      r_phase <= r_phase + 32'd1;
      if (w_sub_wrap) begin
        r_sub <= '0;
        // Phases past the last full bin all land in the top bin.
        if (r_bin != w_bin_max) begin
          r_bin <= r_bin + BIN_W'(1);
        end
      end else begin
        r_sub <= r_sub + 32'd1;
      end
    end
  end

endmodule

// File: rtl/fold_ctrl.sv
// Folding controller: arms on a reference pulse edge, waits an epoch delay, then
// bins the sample stream by phase for cfg_nfold periods, issuing one accumulate
// request per sample to a profile store through a single-entry request register.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_start, i_abort        run control (abort wins)
//   i_pulse_in              reference pulse, rising edge arms the fold
//   i_cfg_*                 period / epoch / bin length / fold count
//   i_sample_valid/_data    input samples
//   o_acc_*, i_acc_ready    accumulate request handshake (acc_first = write, not add)
//   o_busy, o_done, o_cfg_err, o_overrun, o_fold_cnt   status
module fold_ctrl
  import fold_pkg::*;
#(
  parameter int unsigned NBINS  = NBINS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_pulse_in,
  input  logic [31:0]       i_cfg_period,
  input  logic [31:0]       i_cfg_epoch,
  input  logic [15:0]       i_cfg_bin_len,
  input  logic [15:0]       i_cfg_nfold,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  output logic              o_acc_valid,
  output logic [BIN_W-1:0]  o_acc_bin,
  output logic [DATA_W-1:0] o_acc_data,
  output logic              o_acc_first,
  input  logic              i_acc_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err,
  output logic              o_overrun,
  output logic [15:0]       o_fold_cnt
);

  fold_state_e       r_state;
  fold_cfg_t         r_cfg;
  logic              r_pulse;
  logic [31:0]       r_epoch_cnt;
  logic [15:0]       r_fold_cnt;
  logic              r_acc_valid;
  logic [BIN_W-1:0]  r_acc_bin;
  logic [DATA_W-1:0] r_acc_data;
  logic              r_acc_first;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic              r_overrun;

  logic              w_run;
  logic [BIN_W-1:0]  w_bin;
  logic              w_wrap;
  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_epoch_end;
  logic              w_last_fold;

  assign w_run       = (r_state == StFold);
  assign w_accept    = r_acc_valid && i_acc_ready;
  assign w_cfg_ok    = (i_cfg_period != 32'd0) && (i_cfg_bin_len != 16'd0) &&
                       (i_cfg_nfold != 16'd0);
  assign w_epoch_end = (r_cfg.epoch == 32'd0) || (r_epoch_cnt == r_cfg.epoch - 32'd1);
  assign w_last_fold = ((r_fold_cnt + 16'd1) == r_cfg.nfold);

  fold_phase_gen #(
    .NBINS (NBINS),
    .BIN_W (BIN_W)
  ) u_phase_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_period  (r_cfg.period),
    .i_bin_len (r_cfg.bin_len),
    .o_bin     (w_bin),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cfg       <= '0;
      r_pulse     <= 1'b0;
      r_epoch_cnt <= '0;
      r_fold_cnt  <= '0;
      r_acc_valid <= 1'b0;
      r_acc_bin   <= '0;
      r_acc_data  <= '0;
      r_acc_first <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_pulse <= i_pulse_in;
      r_done  <= 1'b0;
      // An accepted request empties the register unless a new sample reloads it below.
      if (w_accept) begin
        r_acc_valid <= 1'b0;
      end

      if ((r_state != StIdle) && i_abort) begin
        r_state     <= StIdle;
        r_busy      <= 1'b0;
        r_acc_valid <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start && !i_abort) begin
              if (w_cfg_ok) begin
                r_cfg       <= '{period:  i_cfg_period,
                                 epoch:   i_cfg_epoch,
                                 bin_len: i_cfg_bin_len,
                                 nfold:   i_cfg_nfold};
                r_fold_cnt  <= '0;
                r_overrun   <= 1'b0;
                r_cfg_err   <= 1'b0;
                r_busy      <= 1'b1;
                r_state     <= StArm;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          StArm: begin
            // Edge against the registered copy: EPOCH starts on the same clock
            // that first registers the high level.
            if (i_pulse_in && !r_pulse) begin
              r_epoch_cnt <= '0;
              r_state     <= StEpoch;
            end
          end
          StEpoch: begin
            if (w_epoch_end) begin
              r_state <= StFold;
            end else begin
              r_epoch_cnt <= r_epoch_cnt + 32'd1;
            end
          end
          StFold: begin
            if (i_sample_valid) begin
              if (!r_acc_valid || i_acc_ready) begin
                r_acc_valid <= 1'b1;
                r_acc_bin   <= w_bin;
                r_acc_data  <= i_sample_data;
                r_acc_first <= (r_fold_cnt == 16'd0);
              end else begin
                r_overrun <= 1'b1;
              end
            end
            if (w_wrap) begin
              r_fold_cnt <= r_fold_cnt + 16'd1;
              if (w_last_fold) begin
                r_state <= StDrain;
              end
            end
          end
          StDrain: begin
            if (!r_acc_valid) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_acc_valid = r_acc_valid;
  assign o_acc_bin   = r_acc_bin;
  assign o_acc_data  = r_acc_data;
  assign o_acc_first = r_acc_first;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_overrun   = r_overrun;
  assign o_fold_cnt  = r_fold_cnt;

endmodule
